vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator for the VGA output path; drives the pixel source (x, y) and the panel (hsync, vsync, blank).
//  Coordinates lead sync/blank by PIPE_DELAY clocks, so a pipelined pixel generator's colour lands aligned with the syncs.
//  Also emits line/frame strobes and a frame counter for animation logic.
// PARAMETERS
//  H_VISIBLE  800   visible pixels per line
//  H_FRONT    40    horizontal front porch, clocks
//  H_SYNC     128   hsync pulse width, clocks
//  H_BACK     88    horizontal back porch, clocks (H_TOTAL = 1056)
//  V_VISIBLE  600   visible lines per frame
//  V_FRONT    1     vertical front porch, lines
//  V_SYNC     4     vsync pulse width, lines
//  V_BACK     23    vertical back porch, lines (V_TOTAL = 628)
//  H_POL      1     hsync active level (1 = active-high)
//  V_POL      1     vsync active level
//  PIPE_DELAY 2     clocks sync/blank lag x/y; legal 0..7
// PORTS
//  clk          in   1   pixel clock (40 MHz for defaults)
//  rst          in   1   synchronous, active-high reset
//  x            out  11  current horizontal count, 0..H_TOTAL-1
//  y            out  11  current vertical count, 0..V_TOTAL-1
//  active       out  1   1 when x < H_VISIBLE && y < V_VISIBLE (aligned with x/y)
//  line_start   out  1   1-clk pulse when x == 0 (aligned with x/y)
//  frame_start  out  1   1-clk pulse when x == 0 && y == 0 (aligned with x/y)
//  frame_count  out  16  completed frames since reset, wraps 0xFFFF -> 0
//  hsync        out  1   horizontal sync, delayed PIPE_DELAY clks vs x/y
//  vsync        out  1   vertical sync, delayed PIPE_DELAY clks vs x/y
//  blank        out  1   ~active, delayed PIPE_DELAY clks vs x/y
// BEHAVIOUR
//  - Reset: x=0, y=0, active=1, line_start=0, frame_start=0, frame_count=0; every delay-line stage and
//    hsync=~H_POL, vsync=~V_POL, blank=1. First clk after rst deasserts: x=1, y=0.
//  - x/y are registered counters. x increments each clk; at x==H_TOTAL-1 the next value is x=0 and y advances.
//    At y==V_TOTAL-1 with x==H_TOTAL-1, the next state is x=0, y=0 and frame_count increments.
//  - active, line_start and frame_start are registered and valid in the same cycle as the x/y they describe.
//  - Raw sync levels are combinational on the counters:
//    hs_raw = H_POL when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC, else ~H_POL.
//    vs_raw = V_POL when V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC, else ~V_POL.
//  - vsync transitions at x==0 of the boundary line (not mid-line).
//  - hs_raw, vs_raw and ~active pass through a PIPE_DELAY-deep register shift line.
//    PIPE_DELAY=0 drives them combinationally from the counters.
//  - Delay-line invariant: the sync/blank output at cycle t+PIPE_DELAY describes the x/y at cycle t.
//  - rst mid-frame: all state returns to reset values on the next edge; stale syncs must not leak out.
//  - No arithmetic overflow: counters compare against H_TOTAL-1 and V_TOTAL-1 exactly. Widths are fixed at 11 bits.
//    Parameters with a total above 2047 are unsupported; flag with a simulation assertion.
// TESTING
//  1 Reset held 5 clks -> x=0, y=0, hsync=0, vsync=0, blank=1, frame_count=0; released -> next clk x=1.
//  2 Defaults, PIPE_DELAY=0: hsync rises when x==840 and falls when x==968; 128 clks high per line.
//  3 Line wrap: x==1055,y==10 -> next clk x=0,y=11, line_start=1 in that cycle only.
//  4 Frame wrap: x==1055,y==627 -> next x=0,y=0, frame_start=1, frame_count +1; vsync high on y 601..604 only.
//  5 PIPE_DELAY=2: blank falls exactly 2 clks after x==0,y==0; hsync edge 2 clks after x==840.
//  6 rst at x=500,y=300 for 1 clk -> x=0,y=0 next edge; hsync/vsync inactive and blank=1 within 1 clk.
//    Then frame_count=0 and the frame restarts cleanly.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Raster timing generator. Pixel coordinates lead the
//                hsync/vsync/blank outputs by PIPE_DELAY clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_VISIBLE  = 800,
    parameter int   H_FRONT    = 40,
    parameter int   H_SYNC     = 128,
    parameter int   H_BACK     = 88,
    parameter int   V_VISIBLE  = 600,
    parameter int   V_FRONT    = 1,
    parameter int   V_SYNC     = 4,
    parameter int   V_BACK     = 23,
    parameter logic H_POL      = 1'b1,
    parameter logic V_POL      = 1'b1,
    parameter int   PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        active,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        hsync,
    output logic        vsync,
    output logic        blank
);

    localparam int          c_h_total_int = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int          c_v_total_int = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [10:0] c_h_last      = 11'(c_h_total_int - 1);
    localparam logic [10:0] c_v_last      = 11'(c_v_total_int - 1);
    localparam logic [10:0] c_h_vis       = 11'(H_VISIBLE);
    localparam logic [10:0] c_v_vis       = 11'(V_VISIBLE);
    localparam logic [10:0] c_hs_start    = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_hs_end      = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_vs_start    = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_vs_end      = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    // Idle level of the {hsync, vsync, blank} bundle
    localparam logic [2:0]  c_idle        = {~H_POL, ~V_POL, 1'b1};

    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_active;
    logic        r_line_start;
    logic        r_frame_start;
    logic [15:0] r_frame_count;

    logic        w_x_last;
    logic        w_y_last;
    logic [10:0] w_x_next;
    logic [10:0] w_y_next;
    logic [2:0]  w_raw;

    always_comb begin
        w_x_last = (r_x == c_h_last);
        w_y_last = (r_y == c_v_last);
        w_x_next = w_x_last ? 11'd0 : r_x + 11'd1;
        w_y_next = r_y;
        if (w_x_last) begin
            w_y_next = w_y_last ? 11'd0 : r_y + 11'd1;
        end
    end

    // Flags are computed from the next coordinates so they line up with x/y
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x           <= 11'd0;
            r_y           <= 11'd0;
            r_active      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_active      <= (w_x_next < c_h_vis) && (w_y_next < c_v_vis);
            r_line_start  <= (w_x_next == 11'd0);
            r_frame_start <= (w_x_next == 11'd0) && (w_y_next == 11'd0);
            if (w_x_last && w_y_last) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_raw[2] = ((r_x >= c_hs_start) && (r_x < c_hs_end)) ? H_POL : ~H_POL;
        w_raw[1] = ((r_y >= c_vs_start) && (r_y < c_vs_end)) ? V_POL : ~V_POL;
        w_raw[0] = ~r_active;
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            // Forced idle during reset so no stale level reaches the panel
            assign {hsync, vsync, blank} = rst ? c_idle : w_raw;
        end else begin : g_delay
            logic [2:0] r_pipe [PIPE_DELAY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= c_idle;
                    end
                end else begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign {hsync, vsync, blank} = r_pipe[PIPE_DELAY-1];
        end
    endgenerate

    assign x           = r_x;
    assign y           = r_y;
    assign active      = r_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

    a_geometry_fits: assert property (@(posedge clk)
        (c_h_total_int <= 2047) && (c_v_total_int <= 2047) &&
        (PIPE_DELAY >= 0) && (PIPE_DELAY <= 7))
        else $error("vga_timing_gen: unsupported timing parameters");

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed self-checking bench for vga_timing_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk;
    logic rst;
    logic rst_s;

    // Default timing, PIPE_DELAY = 2
    logic [10:0] b_x, b_y;
    logic        b_active, b_line_start, b_frame_start;
    logic [15:0] b_frame_count;
    logic        b_hsync, b_vsync, b_blank;

    // Default timing, PIPE_DELAY = 0
    logic [10:0] z_x, z_y;
    logic        z_active, z_line_start, z_frame_start;
    logic [15:0] z_frame_count;
    logic        z_hsync, z_vsync, z_blank;

    // Reduced timing: H_TOTAL = 16, V_TOTAL = 10, hsync active-low, PIPE_DELAY = 1
    logic [10:0] s_x, s_y;
    logic        s_active, s_line_start, s_frame_start;
    logic [15:0] s_frame_count;
    logic        s_hsync, s_vsync, s_blank;

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_gen #(.PIPE_DELAY(2)) u_big (
        .clk(clk), .rst(rst), .x(b_x), .y(b_y), .active(b_active),
        .line_start(b_line_start), .frame_start(b_frame_start),
        .frame_count(b_frame_count), .hsync(b_hsync), .vsync(b_vsync), .blank(b_blank)
    );

    vga_timing_gen #(.PIPE_DELAY(0)) u_big0 (
        .clk(clk), .rst(rst), .x(z_x), .y(z_y), .active(z_active),
        .line_start(z_line_start), .frame_start(z_frame_start),
        .frame_count(z_frame_count), .hsync(z_hsync), .vsync(z_vsync), .blank(z_blank)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_POL(1'b0), .V_POL(1'b1), .PIPE_DELAY(1)
    ) u_small (
        .clk(clk), .rst(rst_s), .x(s_x), .y(s_y), .active(s_active),
        .line_start(s_line_start), .frame_start(s_frame_start),
        .frame_count(s_frame_count), .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int tx, input int ty);
        int n = 0;
        while (!(b_x == 11'(tx) && b_y == 11'(ty)) && n < 20000) begin
            tick();
            n++;
        end
        check_eq("reach_big_x", 32'(b_x), 32'(tx));
        check_eq("reach_big_y", 32'(b_y), 32'(ty));
    endtask

    task automatic run_to_s(input int tx, input int ty);
        int n = 0;
        while (!(s_x == 11'(tx) && s_y == 11'(ty)) && n < 400) begin
            tick();
            n++;
        end
        check_eq("reach_small_x", 32'(s_x), 32'(tx));
        check_eq("reach_small_y", 32'(s_y), 32'(ty));
    endtask

    initial begin
        int cnt_z, cnt_b, cnt_v;

        // Reset held for 5 clocks
        rst   = 1'b1;
        rst_s = 1'b1;
        repeat (5) tick();
        check_eq("rst_x", 32'(b_x), 0);
        check_eq("rst_y", 32'(b_y), 0);
        check_eq("rst_hsync", 32'(b_hsync), 0);
        check_eq("rst_vsync", 32'(b_vsync), 0);
        check_eq("rst_blank", 32'(b_blank), 1);
        check_eq("rst_fcount", 32'(b_frame_count), 0);
        check_eq("rst_active", 32'(b_active), 1);
        check_eq("rst_line_start", 32'(b_line_start), 0);
        check_eq("rst_frame_start", 32'(b_frame_start), 0);
        check_eq("rst_pd0_blank", 32'(z_blank), 1);
        check_eq("rst_pd0_hsync", 32'(z_hsync), 0);
        check_eq("rst_small_hsync", 32'(s_hsync), 1);
        check_eq("rst_small_blank", 32'(s_blank), 1);

        rst   = 1'b0;
        rst_s = 1'b0;
        tick();
        check_eq("rel_x", 32'(b_x), 1);
        check_eq("rel_y", 32'(b_y), 0);
        check_eq("rel_blank_pd2", 32'(b_blank), 1);
        check_eq("rel_blank_pd0", 32'(z_blank), 0);
        tick();
        check_eq("blank_fall_pd2", 32'(b_blank), 0);

        // Horizontal sync placement, both delays
        run_to(839, 0);
        check_eq("hs0_839", 32'(z_hsync), 0);
        tick();
        check_eq("hs0_840", 32'(z_hsync), 1);
        check_eq("hs2_840", 32'(b_hsync), 0);
        tick();
        check_eq("hs2_841", 32'(b_hsync), 0);
        tick();
        check_eq("hs2_842", 32'(b_hsync), 1);

        cnt_z = 0;
        cnt_b = 0;
        for (int i = 0; i < 1056; i++) begin
            tick();
            if (z_hsync) cnt_z++;
            if (b_hsync) cnt_b++;
        end
        check_eq("hs0_width", 32'(cnt_z), 128);
        check_eq("hs2_width", 32'(cnt_b), 128);

        run_to(967, 1);
        check_eq("hs0_967", 32'(z_hsync), 1);
        tick();
        check_eq("hs0_968", 32'(z_hsync), 0);
        check_eq("hs2_968", 32'(b_hsync), 1);
        tick();
        check_eq("hs2_969", 32'(b_hsync), 1);
        tick();
        check_eq("hs2_970", 32'(b_hsync), 0);

        // Line wrap
        run_to(1055, 10);
        check_eq("lw_pre_line_start", 32'(b_line_start), 0);
        tick();
        check_eq("lw_x", 32'(b_x), 0);
        check_eq("lw_y", 32'(b_y), 11);
        check_eq("lw_line_start", 32'(b_line_start), 1);
        check_eq("lw_frame_start", 32'(b_frame_start), 0);
        check_eq("lw_vsync", 32'(b_vsync), 0);
        tick();
        check_eq("lw_x1", 32'(b_x), 1);
        check_eq("lw_line_start_drop", 32'(b_line_start), 0);

        // Visible edge and delayed blank
        run_to(799, 11);
        check_eq("act_799", 32'(b_active), 1);
        tick();
        check_eq("act_800", 32'(b_active), 0);
        check_eq("act0_blank_800", 32'(z_blank), 1);
        tick();
        check_eq("blank2_801", 32'(b_blank), 0);
        tick();
        check_eq("blank2_802", 32'(b_blank), 1);

        // Mid-frame reset while both syncs are active on the small instance
        run_to_s(11, 7);
        check_eq("pre_rst_hsync", 32'(s_hsync), 0);
        check_eq("pre_rst_vsync", 32'(s_vsync), 1);
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        check_eq("mrst_x", 32'(s_x), 0);
        check_eq("mrst_y", 32'(s_y), 0);
        check_eq("mrst_hsync", 32'(s_hsync), 1);
        check_eq("mrst_vsync", 32'(s_vsync), 0);
        check_eq("mrst_blank", 32'(s_blank), 1);
        check_eq("mrst_fcount", 32'(s_frame_count), 0);
        tick();
        check_eq("mrst_rel_x", 32'(s_x), 1);
        check_eq("mrst_rel_blank", 32'(s_blank), 0);

        // Frame wrap
        run_to_s(15, 9);
        check_eq("fw_pre_fcount", 32'(s_frame_count), 0);
        check_eq("fw_pre_frame_start", 32'(s_frame_start), 0);
        tick();
        check_eq("fw_x", 32'(s_x), 0);
        check_eq("fw_y", 32'(s_y), 0);
        check_eq("fw_frame_start", 32'(s_frame_start), 1);
        check_eq("fw_line_start", 32'(s_line_start), 1);
        check_eq("fw_fcount", 32'(s_frame_count), 1);
        tick();
        check_eq("fw_frame_start_drop", 32'(s_frame_start), 0);
        check_eq("fw_fcount_hold", 32'(s_frame_count), 1);

        // Vertical sync on lines 7..8, switching at line boundaries
        run_to_s(0, 7);
        check_eq("vs_y7_x0", 32'(s_vsync), 0);
        tick();
        check_eq("vs_y7_x1", 32'(s_vsync), 1);
        run_to_s(0, 9);
        check_eq("vs_y9_x0", 32'(s_vsync), 1);
        tick();
        check_eq("vs_y9_x1", 32'(s_vsync), 0);
        cnt_v = 0;
        for (int i = 0; i < 160; i++) begin
            tick();
            if (s_vsync) cnt_v++;
        end
        check_eq("vs_width", 32'(cnt_v), 32);
        check_eq("fw2_fcount", 32'(s_frame_count), 2);

        // Active-low hsync on columns 10..12
        run_to_s(10, 0);
        check_eq("shs_10", 32'(s_hsync), 1);
        tick();
        check_eq("shs_11", 32'(s_hsync), 0);
        run_to_s(13, 0);
        check_eq("shs_13", 32'(s_hsync), 0);
        tick();
        check_eq("shs_14", 32'(s_hsync), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
